fir_tap_sequencer: RTL and testbench

Run-time controller for the multi-channel FIR engine. On each audio sample strobe it stores the sample into the history buffer, then walks every tap of every filter, driving the coefficient RAM read address, the history-buffer read address and the MAC control strobes. It also arbitrates the coefficient RAM write port, so host coefficient loads can only land while no filter pass is in progress. It sits between the sample input path and the coefficient store / MAC datapath.

---
 rtl/fir_tap_sequencer_if.sv | 40 ++++
 rtl/fir_tap_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_sequencer_if.sv
// Sample/host/datapath bus of the FIR tap sequencer.
`timescale 1ns/1ps
interface fir_tap_sequencer_if #(
  parameter int unsigned num_of_filters = 4
);
  localparam int unsigned FW = (num_of_filters > 1) ? $clog2(num_of_filters) : 1;

  logic          sample_en;
  logic [7:0]    taps_per_filter;
  logic          coef_wr_req;
  logic          coef_wr_en;
  logic          coef_wr_stall;
  logic          hist_wr_en;
  logic [7:0]    hist_wr_addr;
  logic [7:0]    coef_rd_addr;
  logic [7:0]    data_rd_addr;
  logic          mac_en;
  logic          mac_clr;
  logic          mac_last;
  logic          acc_valid;
  logic [FW-1:0] acc_filter;
  logic          busy;
  logic          overrun;

  // Sample source / host side
  modport master (
    output sample_en, taps_per_filter, coef_wr_req,
    input  coef_wr_en, coef_wr_stall, hist_wr_en, hist_wr_addr,
           coef_rd_addr, data_rd_addr, mac_en, mac_clr, mac_last,
           acc_valid, acc_filter, busy, overrun
  );

  // Sequencer side
  modport slave (
    input  sample_en, taps_per_filter, coef_wr_req,
    output coef_wr_en, coef_wr_stall, hist_wr_en, hist_wr_addr,
           coef_rd_addr, data_rd_addr, mac_en, mac_clr, mac_last,
           acc_valid, acc_filter, busy, overrun
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Per-sample tap walker for the multi-channel FIR engine; also gates host
// coefficient writes so they only land while no filter pass is running.
`timescale 1ns/1ps
module fir_tap_sequencer #(
  parameter int unsigned num_of_filters = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  fir_tap_sequencer_if.slave bus
);
  localparam int unsigned   FW        = (num_of_filters > 1) ? $clog2(num_of_filters) : 1;
  localparam int unsigned   AW        = 8;
  localparam logic [FW-1:0] LAST_FILT = FW'(num_of_filters - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [AW-1:0] r_hist_wr_addr;
  logic [AW-1:0] r_newest;
  logic [AW-1:0] r_nl;
  logic [AW-1:0] r_tap;
  logic [AW-1:0] r_base;
  logic [FW-1:0] r_filt;
  logic [AW-1:0] r_coef_rd_addr;
  logic [AW-1:0] r_data_rd_addr;
  logic          r_a_en;
  logic          r_a_clr;
  logic          r_a_last;
  logic          r_mac_en;
  logic          r_mac_clr;
  logic          r_mac_last;
  logic [FW-1:0] r_m_filt;
  logic          r_acc_valid;
  logic [FW-1:0] r_acc_filter;
  logic          r_overrun;

  logic          w_start;
  logic          w_tap_last;
  logic          w_filt_last;
  logic          w_run_done;
  logic          w_final_acc;
  logic          w_coef_wr_en;
  logic [AW-1:0] w_nl_in;
  logic [AW-1:0] w_tap_nxt;
  logic [AW-1:0] w_base_nxt;
  logic [FW-1:0] w_filt_nxt;

  // Tap/filter advance and run-boundary decode
  always_comb begin
    w_nl_in      = (bus.taps_per_filter == '0) ? AW'(1) : bus.taps_per_filter;
    w_start      = bus.sample_en && (r_state == S_IDLE);
    w_tap_last   = (r_tap == AW'(r_nl - AW'(1)));
    w_filt_last  = (r_filt == LAST_FILT);
    w_run_done   = w_tap_last && w_filt_last;
    w_final_acc  = r_acc_valid && (r_acc_filter == LAST_FILT);
    w_tap_nxt    = w_tap_last ? '0 : AW'(r_tap + AW'(1));
    w_filt_nxt   = w_tap_last ? FW'(r_filt + FW'(1)) : r_filt;
    // Running base replaces filt*Nl; wraps with the 8-bit coefficient space
    w_base_nxt   = w_tap_last ? AW'(r_base + r_nl) : r_base;
    w_coef_wr_en = bus.coef_wr_req && (r_state == S_IDLE) && !bus.sample_en;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start)     w_state_nxt = S_RUN;
      S_RUN:   if (w_run_done)  w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_final_acc) w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Address stage, MAC strobe pipeline and accumulator result tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist_wr_addr <= '0;
      r_newest       <= '0;
      r_nl           <= '0;
      r_tap          <= '0;
      r_base         <= '0;
      r_filt         <= '0;
      r_coef_rd_addr <= '0;
      r_data_rd_addr <= '0;
      r_a_en         <= 1'b0;
      r_a_clr        <= 1'b0;
      r_a_last       <= 1'b0;
      r_mac_en       <= 1'b0;
      r_mac_clr      <= 1'b0;
      r_mac_last     <= 1'b0;
      r_m_filt       <= '0;
      r_acc_valid    <= 1'b0;
      r_acc_filter   <= '0;
      r_overrun      <= 1'b0;
    end else begin
      r_overrun   <= bus.sample_en && (r_state != S_IDLE);
      // One-cycle delay matches the history RAM read latency
      r_mac_en    <= r_a_en;
      r_mac_clr   <= r_a_clr;
      r_mac_last  <= r_a_last;
      r_m_filt    <= r_filt;
      r_acc_valid <= r_mac_en && r_mac_last;
      if (r_mac_en && r_mac_last) r_acc_filter <= r_m_filt;

      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_hist_wr_addr <= AW'(r_hist_wr_addr + AW'(1));
            r_newest       <= r_hist_wr_addr;
            r_nl           <= w_nl_in;
            r_tap          <= '0;
            r_filt         <= '0;
            r_base         <= '0;
            r_coef_rd_addr <= '0;
            r_data_rd_addr <= r_hist_wr_addr;
            r_a_en         <= 1'b1;
            r_a_clr        <= 1'b1;
            r_a_last       <= (w_nl_in == AW'(1));
          end
        end
        S_RUN: begin
          if (w_run_done) begin
            // Addresses hold their last value; only the strobes drop
            r_a_en   <= 1'b0;
            r_a_clr  <= 1'b0;
            r_a_last <= 1'b0;
          end else begin
            r_tap          <= w_tap_nxt;
            r_filt         <= w_filt_nxt;
            r_base         <= w_base_nxt;
            r_coef_rd_addr <= AW'(w_base_nxt + w_tap_nxt);
            r_data_rd_addr <= AW'(r_newest - w_tap_nxt);
            r_a_en         <= 1'b1;
            r_a_clr        <= (w_tap_nxt == '0);
            r_a_last       <= (w_tap_nxt == AW'(r_nl - AW'(1)));
          end
        end
        default: ;
      endcase
    end
  end

  // Output drive; history write and write grant are same-cycle decodes
  assign bus.hist_wr_en    = w_start;
  assign bus.coef_wr_en    = w_coef_wr_en;
  assign bus.coef_wr_stall = bus.coef_wr_req && !w_coef_wr_en;
  assign bus.hist_wr_addr  = r_hist_wr_addr;
  assign bus.coef_rd_addr  = r_coef_rd_addr;
  assign bus.data_rd_addr  = r_data_rd_addr;
  assign bus.mac_en        = r_mac_en;
  assign bus.mac_clr       = r_mac_clr;
  assign bus.mac_last      = r_mac_last;
  assign bus.acc_valid     = r_acc_valid;
  assign bus.acc_filter    = r_acc_filter;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.overrun       = r_overrun;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer: each accepted sample pushes its
// expected MAC and accumulator events; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_fir_tap_sequencer;
  localparam int unsigned F = 4;

  typedef struct { int cyc; int coef; int data; int clr; int last; } mac_exp_t;
  typedef struct { int cyc; int filt; } acc_exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  fir_tap_sequencer_if #(.num_of_filters(F)) bus ();
  fir_tap_sequencer #(.num_of_filters(F)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int       n_chk     = 0;
  int       n_err     = 0;
  int       cyc       = 0;
  int       run_start = -100;
  int       run_end   = -100;
  int       ovr_cyc   = -100;
  int       exp_ptr   = 0;
  mac_exp_t mq[$];
  acc_exp_t aq[$];
  logic [7:0] prev_coef = '0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle monitor: busy window, write grant, overrun and scoreboard pops
  task automatic mon_cycle();
    mac_exp_t m;
    acc_exp_t a;
    logic     eb;
    logic     eg;
    eb = (cyc > run_start) && (cyc <= run_end);
    chk("busy", 32'(bus.busy), 32'(eb));
    if (bus.coef_wr_req) begin
      eg = !eb && !bus.sample_en;
      chk("coef_wr_en", 32'(bus.coef_wr_en), 32'(eg));
      chk("coef_wr_stall", 32'(bus.coef_wr_stall), 32'(!eg));
    end
    chk("overrun", 32'(bus.overrun), 32'(cyc == ovr_cyc));
    if (bus.mac_en) begin
      if (mq.size() == 0) chk("mac_spurious", 32'(1), 32'(0));
      else begin
        m = mq.pop_front();
        chk("mac_cyc", 32'(cyc), 32'(m.cyc));
        chk("coef_rd_addr", 32'(prev_coef), 32'(m.coef));
        chk("data_rd_addr", 32'(prev_data), 32'(m.data));
        chk("mac_clr", 32'(bus.mac_clr), 32'(m.clr));
        chk("mac_last", 32'(bus.mac_last), 32'(m.last));
      end
    end else begin
      chk("mac_idle", 32'({bus.mac_clr, bus.mac_last}), 32'(0));
    end
    if (bus.acc_valid) begin
      if (aq.size() == 0) chk("acc_spurious", 32'(1), 32'(0));
      else begin
        a = aq.pop_front();
        chk("acc_cyc", 32'(cyc), 32'(a.cyc));
        chk("acc_filter", 32'(bus.acc_filter), 32'(a.filt));
      end
    end
  endtask

  always @(negedge clk) begin
    mon_cycle();
    prev_coef <= bus.coef_rd_addr;
    prev_data <= bus.data_rd_addr;
  end

  // Drive one sample from IDLE and push the expected run into the scoreboard
  task automatic send_sample(input logic [7:0] taps);
    int nl;
    nl = (taps == 8'd0) ? 1 : int'(taps);
    @(posedge clk);
    #1;
    bus.sample_en       = 1'b1;
    bus.taps_per_filter = taps;
    #1;
    chk("hist_wr_en", 32'(bus.hist_wr_en), 32'(1));
    chk("hist_wr_addr", 32'(bus.hist_wr_addr), 32'(exp_ptr));
    run_start = cyc;
    run_end   = cyc + int'(F) * nl + 2;
    for (int f = 0; f < int'(F); f++) begin
      for (int t = 0; t < nl; t++) begin
        mq.push_back('{cyc: cyc + 2 + f * nl + t, coef: (f * nl + t) % 256,
                       data: (exp_ptr - t + 256) % 256,
                       clr: (t == 0) ? 1 : 0, last: (t == nl - 1) ? 1 : 0});
      end
      aq.push_back('{cyc: cyc + (f + 1) * nl + 2, filt: f});
    end
    @(posedge clk);
    #1;
    bus.sample_en = 1'b0;
    exp_ptr = (exp_ptr + 1) % 256;
    chk("hist_ptr_adv", 32'(bus.hist_wr_addr), 32'(exp_ptr));
    // Mid-run changes must not affect the latched tap count
    bus.taps_per_filter = 8'($urandom_range(0, 255));
  endtask

  // Bounded wait for the run to finish, then check drain timing and queues
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 32'(1), 32'(0));
    chk("busy_fall_cyc", 32'(cyc), 32'(run_end + 1));
    chk("mac_left", 32'(mq.size()), 32'(0));
    chk("acc_left", 32'(aq.size()), 32'(0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addrs"}, 32'({bus.hist_wr_addr, bus.coef_rd_addr, bus.data_rd_addr}), 32'(0));
    chk({tag, "_flags"}, 32'({bus.coef_wr_en, bus.coef_wr_stall, bus.hist_wr_en, bus.mac_en,
                             bus.mac_clr, bus.mac_last, bus.acc_valid, bus.acc_filter,
                             bus.overrun}), 32'(0));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.sample_en       = 1'b0;
    bus.taps_per_filter = 8'd0;
    bus.coef_wr_req     = 1'b0;
    #2 reset_n = 1'b0;
    #2 check_zero("reset");
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;

    // N=0 acts as N=1, then advance the history pointer to 5
    send_sample(8'd0);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      send_sample(8'd1);
      wait_idle();
    end

    // Coefficient write held across a full N=3 run starting at pointer 5
    @(posedge clk);
    #1 bus.coef_wr_req = 1'b1;
    send_sample(8'd3);
    wait_idle();
    @(posedge clk);
    #1 bus.coef_wr_req = 1'b0;

    // Overrun at RUN cycle 4: no history write, run unchanged
    send_sample(8'd3);
    repeat (3) @(posedge clk);
    #1;
    bus.sample_en = 1'b1;
    #1;
    chk("ovr_hist_wr_en", 32'(bus.hist_wr_en), 32'(0));
    ovr_cyc = cyc + 1;
    @(posedge clk);
    #1;
    bus.sample_en = 1'b0;
    chk("ovr_ptr_hold", 32'(bus.hist_wr_addr), 32'(exp_ptr));
    wait_idle();

    // Asynchronous reset mid-run aborts with no accumulator result
    send_sample(8'd3);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    mq.delete();
    aq.delete();
    run_start = -100;
    run_end   = -100;
    exp_ptr   = 0;
    #1 check_zero("midrun_reset");
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b1;
    send_sample(8'd2);
    wait_idle();

    // Address wrap with N=100 from pointer 2
    send_sample(8'd1);
    wait_idle();
    send_sample(8'd100);
    wait_idle();

    // History pointer wrap 255 -> 0
    while (exp_ptr != 255) begin
      send_sample(8'd1);
      wait_idle();
    end
    send_sample(8'd1);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
